uart_rx_fsm: RTL and testbench

//  Frame-sequencing controller for the UART receiver. Detects the start edge on rx_in and walks

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_edge_bit_counter.sv | 46 ++++
 rtl/uart_rx_fsm.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receiver frame sequencer.
package uart_rx_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PRESCALE   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Per-bit clock counter (wraps at i_edge_last) and data-bit index counter for the UART receiver.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W    = 6,
  parameter int BIT_W      = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic               i_bit_inc,
  input  logic [PRESC_W-1:0] i_edge_last,
  output logic [PRESC_W-1:0] o_edge_cnt,
  output logic [BIT_W-1:0]   o_bit_cnt
);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;

  // The bit index only advances on a bit boundary and folds back to 0 after the last data bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_clr) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_en) begin
      if (r_edge_cnt == i_edge_last) begin
        r_edge_cnt <= '0;
        if (i_bit_inc)
          r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
      end
    end
  end

  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: START/DATA/PARITY/STOP strobes and per-frame result pulse.
// Optional macro UART_RX_BREAK_DET_EN adds a break_det pulse for all-zero frames with a bad stop bit.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESC_W    = 6,
  parameter int BIT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               sampled_bit,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               dat_samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               frame_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic               parity_err,
  output logic               break_det
`else
  output logic               parity_err
`endif
);

  rx_state_e          r_state;
  rx_state_e          w_state_next;
  logic [PRESC_W-1:0] r_prescale;
  logic               r_par_en;
  logic               r_par_flag;
  logic               r_data_valid;
  logic               r_frame_err;
  logic               r_parity_err;
  logic               w_start_det;
  logic               w_bit_end;
  logic               w_chk_pt;
  logic               w_last_bit;
  logic               w_frame_end;
  logic [PRESC_W-1:0] w_edge_last;
  logic [PRESC_W-1:0] w_chk_edge;

  assign w_start_det = (r_state == IDLE) && !rx_in;
  assign w_edge_last = r_prescale - PRESC_W'(1);
  assign w_chk_edge  = r_prescale - PRESC_W'(2);
  assign w_bit_end   = (edge_cnt == w_edge_last);
  assign w_chk_pt    = (edge_cnt == w_chk_edge);
  assign w_last_bit  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign w_frame_end = (r_state == STOP) && w_bit_end;

  uart_rx_edge_bit_counter #(
    .PRESC_W    (PRESC_W),
    .BIT_W      (BIT_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_en        (r_state != IDLE),
    .i_clr       (r_state == IDLE),
    .i_bit_inc   (r_state == DATA),
    .i_edge_last (w_edge_last),
    .o_edge_cnt  (edge_cnt),
    .o_bit_cnt   (bit_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!rx_in) w_state_next = START;
      START:   if (w_bit_end) w_state_next = strt_glitch ? IDLE : DATA;
      DATA:    if (w_bit_end && w_last_bit) w_state_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_state_next = STOP;
      STOP:    if (w_bit_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    dat_samp_en = (r_state != IDLE);
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (r_state)
      START:   strt_chk_en = w_chk_pt;
      DATA:    deser_en    = w_chk_pt;
      PARITY:  par_chk_en  = w_chk_pt;
      STOP:    stp_chk_en  = w_chk_pt;
      default: ;
    endcase
  end

  // Frame configuration is frozen at the start edge so mid-frame input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale <= PRESC_W'(DEF_PRESCALE);
      r_par_en   <= 1'b0;
      r_par_flag <= 1'b0;
    end else if (w_start_det) begin
      r_prescale <= prescale;
      r_par_en   <= par_en;
      r_par_flag <= 1'b0;
    end else if ((r_state == PARITY) && w_bit_end) begin
      r_par_flag <= par_err;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic r_all_zero;
  logic r_break_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_all_zero <= 1'b0;
    else if (w_start_det)             r_all_zero <= 1'b1;
    else if (deser_en && sampled_bit) r_all_zero <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_break_det <= 1'b0;
    else      r_break_det <= w_frame_end && stp_err && r_all_zero;
  end

  assign break_det = r_break_det;
`else
  logic w_unused;
  assign w_unused = sampled_bit;
  localparam logic r_all_zero = 1'b0;
`endif

  // Stop error outranks a stored parity error; at most one pulse per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_data_valid <= w_frame_end && !stp_err && !r_par_flag;
      r_frame_err  <= w_frame_end && stp_err && !r_all_zero;
      r_parity_err <= w_frame_end && !stp_err && r_par_flag;
    end
  end

  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm (default build and UART_RX_BREAK_DET_EN build).
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       sampled_bit = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic       data_valid, frame_err, parity_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
`ifdef UART_RX_BREAK_DET_EN
  logic       break_det;
`endif

  int checks = 0, errors = 0, cyc = 0, d = 0, pulse_cyc = -1, exp_chk = 6;
  int n_strt, n_deser, n_par, n_stp, n_dv, n_fe, n_pe, n_bd, n_bad_edge, max_bit;

  uart_rx_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .sampled_bit (sampled_bit),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
`ifdef UART_RX_BREAK_DET_EN
    .parity_err  (parity_err),
    .break_det   (break_det)
`else
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0;
    n_dv = 0; n_fe = 0; n_pe = 0; n_bd = 0;
    n_bad_edge = 0; max_bit = 0; pulse_cyc = -1;
  endtask

  // Advance one clock and sample 1 ns after the edge, tallying strobes and pulses.
  task automatic tick();
    logic bd;
    @(posedge clk);
    #1;
    cyc++;
`ifdef UART_RX_BREAK_DET_EN
    bd = break_det;
`else
    bd = 1'b0;
`endif
    if (strt_chk_en) begin n_strt++;  if (int'(edge_cnt) != exp_chk) n_bad_edge++; end
    if (deser_en)    begin n_deser++; if (int'(edge_cnt) != exp_chk) n_bad_edge++; end
    if (par_chk_en)  begin n_par++;   if (int'(edge_cnt) != exp_chk) n_bad_edge++; end
    if (stp_chk_en)  begin n_stp++;   if (int'(edge_cnt) != exp_chk) n_bad_edge++; end
    if (data_valid) n_dv++;
    if (frame_err)  n_fe++;
    if (parity_err) n_pe++;
    if (bd)         n_bd++;
    if (data_valid || frame_err || parity_err || bd) pulse_cyc = cyc;
    if (int'(bit_cnt) > max_bit) max_bit = int'(bit_cnt);
  endtask

  // One frame: start detect, then drive line/sampler per bit for len+tail cycles.
  task automatic frame(input int p, input int pe, input logic [7:0] data, input int glitch,
                       input int perr, input int serr, input int p_mid, input int tail);
    int len;
    int seg;
    clear_counts();
    prescale = 6'(p); par_en = pe[0]; strt_glitch = glitch[0];
    par_err = perr[0]; stp_err = serr[0]; exp_chk = p - 2;
    rx_in = 1'b0;
    tick();
    d = cyc;
    chk("start_samp_en", int'(dat_samp_en), 1);
    chk("start_edge0", int'(edge_cnt), 0);
    len = (glitch != 0) ? p : (10 + pe) * p;
    for (int k = 0; k < len + tail; k = cyc - d) begin
      seg = k / p;
      if (glitch != 0) begin
        rx_in = (k >= 2);
      end else if (seg == 0) begin
        rx_in = 1'b0; sampled_bit = 1'b0;
      end else if (seg <= 8) begin
        rx_in = data[seg-1]; sampled_bit = data[seg-1];
      end else begin
        rx_in = 1'b1; sampled_bit = 1'b1;
      end
      if (k == 3 * p) prescale = 6'(p_mid);
      tick();
    end
  endtask

  initial begin
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_samp_en", int'(dat_samp_en), 0);
    chk("rst_edge", int'(edge_cnt), 0);
    chk("rst_bit", int'(bit_cnt), 0);
    chk("rst_pulses", int'(data_valid) + int'(frame_err) + int'(parity_err), 0);
    rst = 1'b1;

    // Reset asserted in the middle of data bit 2
    prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
    tick();
    rx_in = 1'b1;
    repeat (30) tick();
    chk("mid_bit_cnt", int'(bit_cnt), 2);
    chk("mid_edge_cnt", int'(edge_cnt), 6);
    chk("mid_deser_en", int'(deser_en), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_samp_en", int'(dat_samp_en), 0);
    chk("arst_edge", int'(edge_cnt), 0);
    chk("arst_bit", int'(bit_cnt), 0);
    chk("arst_deser", int'(deser_en), 0);
    #2 rst = 1'b1;
    clear_counts();
    repeat (100) tick();
    chk("post_rst_pulses", n_dv + n_fe + n_pe + n_bd, 0);
    chk("post_rst_deser", n_deser, 0);
    chk("post_rst_idle", int'(dat_samp_en), 0);

    // P=8, no parity, 0xA5, good stop
    frame(8, 0, 8'hA5, 0, 0, 0, 8, 5);
    chk("a5_deser_cnt", n_deser, 8);
    chk("a5_bad_edge", n_bad_edge, 0);
    chk("a5_strt_cnt", n_strt, 1);
    chk("a5_par_cnt", n_par, 0);
    chk("a5_stp_cnt", n_stp, 1);
    chk("a5_dv", n_dv, 1);
    chk("a5_other", n_fe + n_pe + n_bd, 0);
    chk("a5_latency", pulse_cyc - d, 80);
    chk("a5_max_bit", max_bit, 7);
    chk("a5_bit_idle", int'(bit_cnt), 0);

    // P=16 with parity, parity error, good stop
    frame(16, 1, 8'h3C, 0, 1, 0, 16, 5);
    chk("par_pe", n_pe, 1);
    chk("par_dv", n_dv, 0);
    chk("par_fe", n_fe + n_bd, 0);
    chk("par_chk_cnt", n_par, 1);
    chk("par_bad_edge", n_bad_edge, 0);
    chk("par_latency", pulse_cyc - d, 176);

    // Stop error outranks parity error
    frame(8, 1, 8'hA5, 0, 1, 1, 8, 5);
    chk("stp_fe", n_fe, 1);
    chk("stp_other", n_dv + n_pe + n_bd, 0);
    chk("stp_latency", pulse_cyc - d, 88);

    // All-zero data with a bad stop bit
    frame(8, 0, 8'h00, 0, 0, 1, 8, 5);
`ifdef UART_RX_BREAK_DET_EN
    chk("brk_bd", n_bd, 1);
    chk("brk_fe", n_fe, 0);
`else
    chk("brk_fe", n_fe, 1);
`endif
    chk("brk_dv_pe", n_dv + n_pe, 0);

    // Short low pulse rejected by the start check
    frame(8, 0, 8'hFF, 1, 0, 0, 8, 10);
    chk("gl_strt_cnt", n_strt, 1);
    chk("gl_deser", n_deser, 0);
    chk("gl_pulses", n_dv + n_fe + n_pe + n_bd, 0);
    chk("gl_idle", int'(dat_samp_en), 0);

    // Back-to-back: P=32 frame with prescale changed to 8 mid-frame, then a P=8 frame
    frame(32, 0, 8'h5A, 0, 0, 0, 8, 0);
    chk("b2b1_dv", n_dv, 1);
    chk("b2b1_latency", pulse_cyc - d, 320);
    chk("b2b1_bad_edge", n_bad_edge, 0);
    chk("b2b1_deser_cnt", n_deser, 8);
    frame(8, 0, 8'hC3, 0, 0, 0, 8, 5);
    chk("b2b2_dv", n_dv, 1);
    chk("b2b2_latency", pulse_cyc - d, 80);
    chk("b2b2_deser_cnt", n_deser, 8);
    chk("b2b2_bad_edge", n_bad_edge, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
